// File: rtl/capture_sequencer.sv
// Capture sequencer: arms the trigger unit, applies a post-trigger offset and streams
// per-segment FIFO write strobes. Optional trigger timeout enabled by CAPTURE_SEQ_TIMEOUT_EN.
module capture_sequencer #(
   parameter int SAMPLE_W  = 17,
   parameter int SEG_W     = 16,
   parameter int OFFSET_W  = 32,
   parameter int TIMEOUT_W = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 arm_i,
   input  logic                 abort_i,
   input  logic [OFFSET_W-1:0]  trigger_offset_i,
   input  logic [SAMPLE_W-1:0]  samples_i,
   input  logic [SEG_W-1:0]     segments_i,
   input  logic [TIMEOUT_W-1:0] timeout_i,
   output logic                 arm_o,
   input  logic                 capture_go_i,
   output logic                 capture_done_o,
   output logic                 fifo_wr_o,
   input  logic                 fifo_full_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 overflow_o,
   output logic                 timeout_o,
   output logic [SEG_W-1:0]     segment_cnt_o
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARMED   = 3'd1,
      S_OFFSET  = 3'd2,
      S_CAPTURE = 3'd3,
      S_REARM   = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   localparam logic [OFFSET_W-1:0] OFF_ZERO = {OFFSET_W{1'b0}};
   localparam logic [OFFSET_W-1:0] OFF_ONE  = OFFSET_W'(1);
   localparam logic [SAMPLE_W-1:0] SMP_ZERO = {SAMPLE_W{1'b0}};
   localparam logic [SAMPLE_W-1:0] SMP_ONE  = SAMPLE_W'(1);
   localparam logic [SEG_W-1:0]    SEG_ZERO = {SEG_W{1'b0}};
   localparam logic [SEG_W-1:0]    SEG_ONE  = SEG_W'(1);

   state_t              state_r;
   state_t              state_s;
   logic                arm_prev_r;
   logic [OFFSET_W-1:0] offset_r;
   logic [OFFSET_W-1:0] off_cnt_r;
   logic [SAMPLE_W-1:0] samples_r;
   logic [SAMPLE_W-1:0] smp_cnt_r;
   logic [SEG_W-1:0]    segments_r;
   logic [SEG_W-1:0]    seg_cnt_r;
   logic                arm_r;
   logic                capture_done_r;
   logic                fifo_wr_r;
   logic                busy_r;
   logic                done_r;
   logic                overflow_r;
   logic                timeout_r;

   logic                arm_rise_s;
   logic                start_s;
   logic                abort_s;
   logic                ovf_s;
   logic                tmo_hit_s;
   logic                tmo_exp_s;
   logic                seg_inc_s;

   assign arm_rise_s = arm_i & ~arm_prev_r;

`ifdef CAPTURE_SEQ_TIMEOUT_EN
   localparam logic [TIMEOUT_W-1:0] TMO_ZERO = {TIMEOUT_W{1'b0}};
   localparam logic [TIMEOUT_W-1:0] TMO_ONE  = TIMEOUT_W'(1);

   logic [TIMEOUT_W-1:0] timeout_cfg_r;
   logic [TIMEOUT_W-1:0] tmo_cnt_r;

   assign tmo_exp_s = (state_r == S_ARMED) && (timeout_cfg_r != TMO_ZERO) &&
                      (tmo_cnt_r == timeout_cfg_r - TMO_ONE);

   // Trigger-wait counter, restarted on every entry into ARMED
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         timeout_cfg_r <= TMO_ZERO;
         tmo_cnt_r     <= TMO_ZERO;
      end else begin
         if (start_s) begin
            timeout_cfg_r <= timeout_i;
         end else begin
            timeout_cfg_r <= timeout_cfg_r;
         end
         if ((state_r == S_ARMED) && (state_s == S_ARMED) && (timeout_cfg_r != TMO_ZERO)) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
         end else begin
            tmo_cnt_r <= TMO_ZERO;
         end
      end
   end
`else
   // timeout_i has no effect in this build; the reduction only keeps the input referenced
   assign tmo_exp_s = 1'b0 & (^timeout_i);
`endif

   // Next-state decode; abort outranks every other event outside IDLE
   always_comb begin
      state_s   = state_r;
      start_s   = 1'b0;
      abort_s   = 1'b0;
      ovf_s     = 1'b0;
      tmo_hit_s = 1'b0;
      seg_inc_s = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (arm_rise_s && !abort_i) begin
               state_s = S_ARMED;
               start_s = 1'b1;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_ARMED: begin
            if (abort_i) begin
               state_s = S_IDLE;
               abort_s = 1'b1;
            end else if (capture_go_i || tmo_exp_s) begin
               tmo_hit_s = ~capture_go_i;
               if (offset_r == OFF_ZERO) begin
                  state_s = S_CAPTURE;
               end else begin
                  state_s = S_OFFSET;
               end
            end else begin
               state_s = S_ARMED;
            end
         end
         S_OFFSET: begin
            if (abort_i) begin
               state_s = S_IDLE;
               abort_s = 1'b1;
            end else if (off_cnt_r == offset_r - OFF_ONE) begin
               state_s = S_CAPTURE;
            end else begin
               state_s = S_OFFSET;
            end
         end
         S_CAPTURE: begin
            if (abort_i) begin
               state_s = S_IDLE;
               abort_s = 1'b1;
            end else if (fifo_full_i) begin
               state_s   = S_REARM;
               ovf_s     = 1'b1;
               seg_inc_s = 1'b1;
            end else if (smp_cnt_r == samples_r - SMP_ONE) begin
               state_s   = S_REARM;
               seg_inc_s = 1'b1;
            end else begin
               state_s = S_CAPTURE;
            end
         end
         S_REARM: begin
            if (abort_i) begin
               state_s = S_IDLE;
               abort_s = 1'b1;
            end else if (overflow_r || (seg_cnt_r == segments_r)) begin
               state_s = S_DONE;
            end else begin
               state_s = S_ARMED;
            end
         end
         S_DONE: begin
            if (abort_i) begin
               state_s = S_IDLE;
               abort_s = 1'b1;
            end else if (!arm_i) begin
               state_s = S_IDLE;
            end else begin
               state_s = S_DONE;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // State, latched configuration, counters and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r        <= S_IDLE;
         arm_prev_r     <= 1'b0;
         offset_r       <= OFF_ZERO;
         off_cnt_r      <= OFF_ZERO;
         samples_r      <= SMP_ZERO;
         smp_cnt_r      <= SMP_ZERO;
         segments_r     <= SEG_ZERO;
         seg_cnt_r      <= SEG_ZERO;
         arm_r          <= 1'b0;
         capture_done_r <= 1'b0;
         fifo_wr_r      <= 1'b0;
         busy_r         <= 1'b0;
         done_r         <= 1'b0;
         overflow_r     <= 1'b0;
         timeout_r      <= 1'b0;
      end else begin
         state_r    <= state_s;
         arm_prev_r <= arm_i;

         if (start_s) begin
            offset_r   <= trigger_offset_i;
            samples_r  <= (samples_i == SMP_ZERO) ? SMP_ONE : samples_i;
            segments_r <= (segments_i == SEG_ZERO) ? SEG_ONE : segments_i;
            seg_cnt_r  <= SEG_ZERO;
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
            timeout_r  <= 1'b0;
         end else begin
            if (seg_inc_s) begin
               seg_cnt_r <= seg_cnt_r + SEG_ONE;
            end
            if (state_s == S_DONE) begin
               done_r <= 1'b1;
            end
            if (ovf_s) begin
               overflow_r <= 1'b1;
            end
            if (tmo_hit_s) begin
               timeout_r <= 1'b1;
            end
         end

         // Counters restart on every entry, so they never need to wrap
         if ((state_r == S_OFFSET) && (state_s == S_OFFSET)) begin
            off_cnt_r <= off_cnt_r + OFF_ONE;
         end else begin
            off_cnt_r <= OFF_ZERO;
         end
         if ((state_r == S_CAPTURE) && (state_s == S_CAPTURE)) begin
            smp_cnt_r <= smp_cnt_r + SMP_ONE;
         end else begin
            smp_cnt_r <= SMP_ZERO;
         end

         arm_r          <= (state_s == S_ARMED) || (state_s == S_OFFSET) || (state_s == S_CAPTURE);
         busy_r         <= (state_s == S_ARMED) || (state_s == S_OFFSET) ||
                           (state_s == S_CAPTURE) || (state_s == S_REARM);
         fifo_wr_r      <= (state_s == S_CAPTURE);
         capture_done_r <= (state_s == S_REARM) || abort_s;
      end
   end

   assign arm_o          = arm_r;
   assign capture_done_o = capture_done_r;
   assign fifo_wr_o      = fifo_wr_r;
   assign busy_o         = busy_r;
   assign done_o         = done_r;
   assign overflow_o     = overflow_r;
   assign timeout_o      = timeout_r;
   assign segment_cnt_o  = seg_cnt_r;

endmodule

// File: tb/tb_capture_sequencer.sv
// Randomized scoreboard bench for capture_sequencer: expected strobe and pulse times
// come from an event-schedule model of the capture rules; a monitor pops and compares.
module tb_capture_sequencer;

   localparam int SAMPLE_W  = 17;
   localparam int SEG_W     = 16;
   localparam int OFFSET_W  = 32;
   localparam int TIMEOUT_W = 32;

   logic                 clk;
   logic                 reset;
   logic                 arm_i;
   logic                 abort_i;
   logic [OFFSET_W-1:0]  trigger_offset_i;
   logic [SAMPLE_W-1:0]  samples_i;
   logic [SEG_W-1:0]     segments_i;
   logic [TIMEOUT_W-1:0] timeout_i;
   logic                 arm_o;
   logic                 capture_go_i;
   logic                 capture_done_o;
   logic                 fifo_wr_o;
   logic                 fifo_full_i;
   logic                 busy_o;
   logic                 done_o;
   logic                 overflow_o;
   logic                 timeout_o;
   logic [SEG_W-1:0]     segment_cnt_o;

   int  cyc = 0;
   int  n_checks = 0;
   int  n_pass = 0;
   bit  mon_en = 1'b0;

   int  exp_wr_q[$];
   int  exp_done_q[$];
   int  exp_seg_q[$];
   bit  go_drv[int];
   bit  full_drv[int];
   int  arm_lo_q[$];
   int  arm_hi_q[$];

   capture_sequencer #(
      .SAMPLE_W(SAMPLE_W), .SEG_W(SEG_W), .OFFSET_W(OFFSET_W), .TIMEOUT_W(TIMEOUT_W)
   ) dut (
      .clk(clk), .reset(reset), .arm_i(arm_i), .abort_i(abort_i),
      .trigger_offset_i(trigger_offset_i), .samples_i(samples_i), .segments_i(segments_i),
      .timeout_i(timeout_i), .arm_o(arm_o), .capture_go_i(capture_go_i),
      .capture_done_o(capture_done_o), .fifo_wr_o(fifo_wr_o), .fifo_full_i(fifo_full_i),
      .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o), .timeout_o(timeout_o),
      .segment_cnt_o(segment_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge counter: at a negedge, cyc is the index of the posedge just passed
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
   endtask

   function automatic bit arm_expected(input int c, input int lim);
      for (int i = 0; i < arm_lo_q.size(); i++)
         if (c >= arm_lo_q[i] && c <= arm_hi_q[i] && c < lim) return 1'b1;
      return 1'b0;
   endfunction

   // Monitor: every strobe and done pulse is matched against the scoreboard
   always @(negedge clk) begin
      if (mon_en) begin
         if (fifo_wr_o) begin
            if (exp_wr_q.size() == 0) check("unexpected_fifo_wr", cyc, -1);
            else check("fifo_wr_edge", cyc, exp_wr_q.pop_front());
         end
         if (capture_done_o) begin
            if (exp_done_q.size() == 0) check("unexpected_capture_done", cyc, -1);
            else begin
               check("capture_done_edge", cyc, exp_done_q.pop_front());
               check("segment_cnt_at_done", segment_cnt_o, exp_seg_q.pop_front());
               check("arm_low_at_done", arm_o, 0);
               check("wr_low_at_done", fifo_wr_o, 0);
            end
         end
      end
   end

   // trig_mode: 0 random trigger, 1 no trigger, 2 trigger exactly at timeout expiry
   // abort_mode: 0 none, 1 mid-OFFSET, 2 mid-CAPTURE, 3 while waiting in ARMED
   task automatic run(input int off, input int ns, input int nseg, input int to,
                      input int ovf_seg, input int ovf_k, input int abort_mode,
                      input int trig_mode, input bit glitch);
      int n_eff, segs_eff, a, a0, t, t0, d, last_edge, ab, lim, busy_end, exp_seg, kept;
      bit exp_ovf, exp_tmo, exp_done, hang;
      int wr_l[$];
      int dn_l[$];
      int sg_l[$];
      n_eff = (ns == 0) ? 1 : ns;
      segs_eff = (nseg == 0) ? 1 : nseg;
      go_drv.delete(); full_drv.delete(); arm_lo_q.delete(); arm_hi_q.delete();
      exp_seg = 0; exp_ovf = 1'b0; exp_tmo = 1'b0; hang = 1'b0; t0 = -1; t = -1;

      @(negedge clk);
      trigger_offset_i = OFFSET_W'(off);
      samples_i        = SAMPLE_W'(ns);
      segments_i       = SEG_W'(nseg);
      timeout_i        = TIMEOUT_W'(to);
      arm_i            = 1'b1;
      a0 = cyc + 1;
      a = a0;
      last_edge = a0;

      for (int s = 0; s < segs_eff; s++) begin
         if (trig_mode == 0) begin
            t = a + 1 + int'($urandom_range(0, 3));
            go_drv[t - 1] = 1'b1;
            if ($urandom_range(0, 1) == 1) go_drv[t] = 1'b1;
            if ($urandom_range(0, 1) == 1) full_drv[t - 1] = 1'b1;
         end else if (trig_mode == 2) begin
            t = a + to;
            go_drv[t - 1] = 1'b1;
         end else begin
`ifdef CAPTURE_SEQ_TIMEOUT_EN
            if (to > 0) begin
               t = a + to;
               exp_tmo = 1'b1;
            end else t = -1;
`else
            t = -1;
`endif
         end
         if (t < 0) begin
            hang = 1'b1;
            arm_lo_q.push_back(a);
            arm_hi_q.push_back(a + 1000);
            break;
         end
         if (s == 0) t0 = t;
         d = t + off + n_eff;
         for (int k = 0; k < n_eff; k++) begin
            wr_l.push_back(t + off + k);
            if (s == ovf_seg && k == ovf_k) begin
               full_drv[t + off + k] = 1'b1;
               exp_ovf = 1'b1;
               d = t + off + k + 1;
               break;
            end
         end
         exp_seg++;
         dn_l.push_back(d);
         sg_l.push_back(exp_seg);
         arm_lo_q.push_back(a);
         arm_hi_q.push_back(d - 1);
         last_edge = d;
         a = d + 1;
         if (exp_ovf) break;
      end

      ab = -1;
      if (abort_mode == 1) ab = t0 + 1;
      else if (abort_mode == 2) ab = t0 + off + 1;
      else if (abort_mode == 3) ab = a0 + 30;
      lim = 1 << 30;
      exp_done = !hang;
      kept = 0;
      foreach (wr_l[i]) if (ab < 0 || wr_l[i] < ab) exp_wr_q.push_back(wr_l[i]);
      foreach (dn_l[i]) begin
         if (ab < 0 || dn_l[i] < ab) begin
            exp_done_q.push_back(dn_l[i]);
            exp_seg_q.push_back(sg_l[i]);
            kept++;
         end
      end
      if (ab >= 0) begin
         exp_seg = kept;
         exp_done_q.push_back(ab);
         exp_seg_q.push_back(kept);
         last_edge = ab;
         lim = ab;
         exp_done = 1'b0;
      end
      busy_end = (ab >= 0) ? ab - 1 : last_edge;

      while (cyc <= last_edge + 2) begin
         capture_go_i = go_drv.exists(cyc) ? 1'b1 : 1'b0;
         fifo_full_i  = full_drv.exists(cyc) ? 1'b1 : 1'b0;
         abort_i      = (cyc == ab - 1) ? 1'b1 : 1'b0;
         arm_i        = (glitch && (cyc == a0 || cyc == a0 + 1)) ? 1'b0 : 1'b1;
         if (cyc >= a0) begin
            trigger_offset_i = OFFSET_W'($urandom);
            samples_i        = SAMPLE_W'($urandom);
            segments_i       = SEG_W'($urandom);
            timeout_i        = TIMEOUT_W'($urandom_range(1, 3));
            check("arm_o", arm_o, arm_expected(cyc, lim));
            check("busy_o", busy_o, longint'(cyc <= busy_end));
            check("done_o", done_o, longint'(exp_done && cyc > last_edge));
         end
         @(negedge clk);
      end

      capture_go_i = 1'b0; fifo_full_i = 1'b0; abort_i = 1'b0;
      check("final_done", done_o, exp_done);
      check("final_busy", busy_o, 0);
      check("final_overflow", overflow_o, exp_ovf);
      check("final_timeout", timeout_o, exp_tmo);
      check("final_segment_cnt", segment_cnt_o, exp_seg);
      check("pending_writes", exp_wr_q.size(), 0);
      check("pending_done_pulses", exp_done_q.size(), 0);
      exp_wr_q.delete(); exp_done_q.delete(); exp_seg_q.delete();
      arm_i = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_busy", busy_o, 0);
      check("idle_arm", arm_o, 0);
      check("sticky_done", done_o, exp_done);
   endtask

   initial begin
      reset = 1'b1;
      arm_i = 1'b0; abort_i = 1'b0; capture_go_i = 1'b0; fifo_full_i = 1'b0;
      trigger_offset_i = '0; samples_i = '0; segments_i = '0; timeout_i = '0;
      #2 reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_arm", arm_o, 0);
      check("rst_capture_done", capture_done_o, 0);
      check("rst_fifo_wr", fifo_wr_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_overflow", overflow_o, 0);
      check("rst_timeout", timeout_o, 0);
      check("rst_segment_cnt", segment_cnt_o, 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("post_rst_busy", busy_o, 0);
      mon_en = 1'b1;

      run(0, 4, 1, 0, -1, 0, 0, 0, 1'b0);
      run(3, 2, 1, 0, -1, 0, 0, 0, 1'b0);
      run(0, 2, 3, 0, -1, 0, 0, 0, 1'b0);
      run(1, 5, 2, 0, 0, 1, 0, 0, 1'b0);
      run(4, 3, 1, 0, -1, 0, 1, 0, 1'b0);
      run(0, 5, 1, 0, -1, 0, 2, 0, 1'b0);
      run(2, 3, 2, 0, -1, 0, 0, 0, 1'b1);
      run(1, 0, 0, 0, -1, 0, 0, 0, 1'b0);
`ifdef CAPTURE_SEQ_TIMEOUT_EN
      run(0, 3, 1, 10, -1, 0, 0, 1, 1'b0);
      run(0, 3, 1, 10, -1, 0, 0, 2, 1'b0);
      run(2, 2, 2, 5, -1, 0, 0, 1, 1'b0);
`else
      run(0, 3, 1, 10, -1, 0, 3, 1, 1'b0);
`endif

      for (int i = 0; i < 14; i++) begin
         int off, ns, nseg, ne, se, ovs, ovk, am;
         bit gl;
         off = int'($urandom_range(0, 5));
         ns = int'($urandom_range(0, 6));
         nseg = int'($urandom_range(0, 3));
         ne = (ns == 0) ? 1 : ns;
         se = (nseg == 0) ? 1 : nseg;
         ovs = -1; ovk = 0; am = 0;
         case ($urandom_range(0, 3))
            0: begin
               ovs = int'($urandom_range(0, se - 1));
               ovk = int'($urandom_range(0, ne - 1));
            end
            1: begin
               if (off >= 2) am = 1;
               else if (ne >= 2) am = 2;
               else am = 0;
            end
            default: am = 0;
         endcase
         gl = (am == 0) && ($urandom_range(0, 1) == 1);
         run(off, ns, nseg, 0, ovs, ovk, am, 0, gl);
      end

      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
